// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file:
//   - default values for the regfile_mp parameters
//   - encoding of the clear-sweep FSM states
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_BYPASS     = 1;
    localparam int DEF_ZERO_REG   = 1;
    localparam int DEF_DBG_ADDR   = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// -----------------------------------------------------------------------------
// regfile_clr_fsm
// Sequential clear controller for the register file. A Clr request in IDLE
// starts a sweep that zeroes one register per cycle, index 0 upward, and then
// returns to IDLE after the last index.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_clr      clear request (ignored while a sweep is running)
//   o_busy     high while the sweep is running
//   o_clr_en   storage must zero register o_clr_idx this cycle
//   o_clr_idx  index being zeroed this cycle
// -----------------------------------------------------------------------------
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    output logic                  o_busy,
    output logic                  o_clr_en,
    output logic [ADDR_WIDTH-1:0] o_clr_idx
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

    clr_state_e            r_state;
    clr_state_e            w_nextState;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_nextCnt;

    // State and sweep counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Next-state and outputs. The counter simply increments through the
    // last index, so it wraps back to 0 on the same edge the FSM leaves SWEEP.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        o_busy      = 1'b0;
        o_clr_en    = 1'b0;
        o_clr_idx   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_clr) begin
                    w_nextState = SWEEP;
                    w_nextCnt   = '0;
                end
            end
            SWEEP: begin
                o_busy    = 1'b1;
                o_clr_en  = 1'b1;
                w_nextCnt = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == LAST_IDX) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Register file with two write ports, two combinational read ports, optional
// same-cycle write-to-read forwarding, optional hard-wired zero register, a
// debug tap on one fixed register and a multi-cycle sequential clear.
//
// Ports:
//   Clk              clock, rising edge
//   Rst              synchronous active-high reset (clears everything)
//   WE0/W0/Din0      write port 0 enable / address / data
//   WE1/W1/Din1      write port 1 enable / address / data (wins on collision)
//   Addr1, Addr2     read addresses
//   R1, R2           combinational read data
//   Clr              start a clear sweep
//   Busy             clear sweep in progress; writes are discarded meanwhile
//   DbgOut           stored contents of register DBG_ADDR (never forwarded)
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BYPASS     = DEF_BYPASS,
    parameter int ZERO_REG   = DEF_ZERO_REG,
    parameter int DBG_ADDR   = DEF_DBG_ADDR
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  WE0,
    input  logic [ADDR_WIDTH-1:0] W0,
    input  logic [DATA_WIDTH-1:0] Din0,
    input  logic                  WE1,
    input  logic [ADDR_WIDTH-1:0] W1,
    input  logic [DATA_WIDTH-1:0] Din1,
    input  logic [ADDR_WIDTH-1:0] Addr1,
    input  logic [ADDR_WIDTH-1:0] Addr2,
    output logic [DATA_WIDTH-1:0] R1,
    output logic [DATA_WIDTH-1:0] R2,
    input  logic                  Clr,
    output logic                  Busy,
    output logic [DATA_WIDTH-1:0] DbgOut
);

    localparam int                    DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] DBG_IDX = ADDR_WIDTH'(DBG_ADDR);
    localparam logic                  HAS_ZERO = (ZERO_REG != 0);
    localparam logic                  HAS_BYP  = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];

    logic                  w_busy;
    logic                  w_clrEn;
    logic [ADDR_WIDTH-1:0] w_clrIdx;
    logic                  w_wr0Valid;
    logic                  w_wr1Valid;
    logic                  w_bypassOn;

    regfile_clr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_fsm (
        .i_clk     (Clk),
        .i_rst     (Rst),
        .i_clr     (Clr),
        .o_busy    (w_busy),
        .o_clr_en  (w_clrEn),
        .o_clr_idx (w_clrIdx)
    );

    // A write is "valid" when enabled and not aimed at the hard-wired zero
    // register. Busy gating is applied separately for storage and bypass.
    assign w_wr0Valid = WE0 && !(HAS_ZERO && (W0 == '0));
    assign w_wr1Valid = WE1 && !(HAS_ZERO && (W1 == '0));
    assign w_bypassOn = HAS_BYP && !w_busy;

    // Storage. Reset beats the sweep, and the sweep beats both write ports.
    // Port 1 is written last so it wins when both ports hit the same address.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_clrEn) begin
            r_regs[w_clrIdx] <= '0;
        end else begin
            if (w_wr0Valid) begin
                r_regs[W0] <= Din0;
            end
            if (w_wr1Valid) begin
                r_regs[W1] <= Din1;
            end
        end
    end

    // Read port 1: storage, optionally overridden by an in-flight write
    // (port 1 first), with the zero register forced last.
    always_comb begin
        R1 = r_regs[Addr1];
        if (w_bypassOn && w_wr1Valid && (W1 == Addr1)) begin
            R1 = Din1;
        end else if (w_bypassOn && w_wr0Valid && (W0 == Addr1)) begin
            R1 = Din0;
        end
        if (HAS_ZERO && (Addr1 == '0)) begin
            R1 = '0;
        end
    end

    // Read port 2: same selection as read port 1
    always_comb begin
        R2 = r_regs[Addr2];
        if (w_bypassOn && w_wr1Valid && (W1 == Addr2)) begin
            R2 = Din1;
        end else if (w_bypassOn && w_wr0Valid && (W0 == Addr2)) begin
            R2 = Din0;
        end
        if (HAS_ZERO && (Addr2 == '0)) begin
            R2 = '0;
        end
    end

    assign Busy   = w_busy;
    assign DbgOut = r_regs[DBG_IDX];

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed self-checking bench for regfile_mp. Two instances share all
// inputs: dut (default parameters, forwarding on) and dutNb (forwarding off).
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic        Clk;
    logic        Rst;
    logic        WE0;
    logic [4:0]  W0;
    logic [31:0] Din0;
    logic        WE1;
    logic [4:0]  W1;
    logic [31:0] Din1;
    logic [4:0]  Addr1;
    logic [4:0]  Addr2;
    logic        Clr;

    logic [31:0] R1;
    logic [31:0] R2;
    logic        Busy;
    logic [31:0] DbgOut;

    logic [31:0] R1Nb;
    logic [31:0] R2Nb;
    logic        BusyNb;
    logic [31:0] DbgOutNb;

    int nCompared;
    int nMismatched;

    regfile_mp dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .WE0    (WE0),
        .W0     (W0),
        .Din0   (Din0),
        .WE1    (WE1),
        .W1     (W1),
        .Din1   (Din1),
        .Addr1  (Addr1),
        .Addr2  (Addr2),
        .R1     (R1),
        .R2     (R2),
        .Clr    (Clr),
        .Busy   (Busy),
        .DbgOut (DbgOut)
    );

    regfile_mp #(
        .BYPASS (0)
    ) dutNb (
        .Clk    (Clk),
        .Rst    (Rst),
        .WE0    (WE0),
        .W0     (W0),
        .Din0   (Din0),
        .WE1    (WE1),
        .W1     (W1),
        .Din1   (Din1),
        .Addr1  (Addr1),
        .Addr2  (Addr2),
        .R1     (R1Nb),
        .R2     (R2Nb),
        .Clr    (Clr),
        .Busy   (BusyNb),
        .DbgOut (DbgOutNb)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Advance one rising edge and park on the following falling edge, where
    // inputs are driven and outputs are sampled.
    task automatic tick;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic applyStimulus(input logic we0, input logic [4:0] w0, input logic [31:0] d0,
                                 input logic we1, input logic [4:0] w1, input logic [31:0] d1);
        WE0  = we0;
        W0   = w0;
        Din0 = d0;
        WE1  = we1;
        W1   = w1;
        Din1 = d1;
    endtask

    // Fill every register with base + index through write port 0
    task automatic fillAll(input logic [31:0] base);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, i[4:0], base + i, 1'b0, 5'd0, 32'd0);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        tick();
        tick();
        Rst   = 1'b0;
        Addr1 = 5'd5;
        Addr2 = 5'd7;
        #1;
        nCompared++;
        if (R1 !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_r1: got %h want %h", R1, 32'd0);
        end
        nCompared++;
        if (R2 !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_r2: got %h want %h", R2, 32'd0);
        end
        nCompared++;
        if (DbgOut !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_dbg: got %h want %h", DbgOut, 32'd0);
        end
        nCompared++;
        if (Busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_busy: got %b want 0", Busy);
        end
    endtask

    task automatic test_write_read;
        tick();
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        Addr1 = 5'd5;
        #1;
        nCompared++;
        if (R1 !== 32'hDEADBEEF) begin
            nMismatched++;
            $display("[TB] FAIL bypass_p0: got %h want %h", R1, 32'hDEADBEEF);
        end
        nCompared++;
        if (R1Nb !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL nobypass_p0: got %h want %h", R1Nb, 32'd0);
        end
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        nCompared++;
        if (R1 !== 32'hDEADBEEF) begin
            nMismatched++;
            $display("[TB] FAIL stored_r5: got %h want %h", R1, 32'hDEADBEEF);
        end
        nCompared++;
        if (R1Nb !== 32'hDEADBEEF) begin
            nMismatched++;
            $display("[TB] FAIL stored_r5_nb: got %h want %h", R1Nb, 32'hDEADBEEF);
        end
    endtask

    task automatic test_same_addr;
        tick();
        applyStimulus(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
        Addr2 = 5'd7;
        #1;
        nCompared++;
        if (R2 !== 32'd2) begin
            nMismatched++;
            $display("[TB] FAIL bypass_prio: got %h want %h", R2, 32'd2);
        end
        nCompared++;
        if (R2Nb !== 32'h55) begin
            nMismatched++;
            $display("[TB] FAIL nobypass_old: got %h want %h", R2Nb, 32'h55);
        end
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        nCompared++;
        if (R2 !== 32'd2) begin
            nMismatched++;
            $display("[TB] FAIL collide_store: got %h want %h", R2, 32'd2);
        end
        nCompared++;
        if (R2Nb !== 32'd2) begin
            nMismatched++;
            $display("[TB] FAIL collide_store_nb: got %h want %h", R2Nb, 32'd2);
        end
    endtask

    task automatic test_zero_reg_dbg;
        tick();
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
        Addr1 = 5'd0;
        #1;
        nCompared++;
        if (R1 !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL r0_bypass: got %h want %h", R1, 32'd0);
        end
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h1234);
        #1;
        nCompared++;
        if (R1 !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL r0_stored: got %h want %h", R1, 32'd0);
        end
        nCompared++;
        if (DbgOut !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL dbg_no_bypass: got %h want %h", DbgOut, 32'd0);
        end
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        nCompared++;
        if (DbgOut !== 32'h1234) begin
            nMismatched++;
            $display("[TB] FAIL dbg_r10: got %h want %h", DbgOut, 32'h1234);
        end
    endtask

    task automatic test_sweep;
        int busyCnt;
        logic [31:0] want;
        tick();
        fillAll(32'h100);
        Clr = 1'b1;
        #1;
        nCompared++;
        if (Busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL busy_pre_clr: got %b want 0", Busy);
        end
        tick();
        Clr = 1'b0;
        // Keep trying to overwrite r1 for the whole sweep; it must never stick
        applyStimulus(1'b1, 5'd1, 32'hDEAD0001, 1'b0, 5'd0, 32'd0);
        Addr1 = 5'd1;
        #1;
        nCompared++;
        if (Busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL busy_start: got %b want 1", Busy);
        end
        nCompared++;
        if (R1 !== 32'h101) begin
            nMismatched++;
            $display("[TB] FAIL sweep_no_bypass: got %h want %h", R1, 32'h101);
        end
        busyCnt = 1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 8) Clr = 1'b1;
            if (c == 9) Clr = 1'b0;
            tick();
            if (c == 3) begin
                Addr1 = 5'd0;
                Addr2 = 5'd1;
                #1;
                nCompared++;
                if (R2 !== 32'd0) begin
                    nMismatched++;
                    $display("[TB] FAIL sweep3_r1: got %h want %h", R2, 32'd0);
                end
                Addr1 = 5'd2;
                Addr2 = 5'd3;
                #1;
                nCompared++;
                if (R1 !== 32'd0) begin
                    nMismatched++;
                    $display("[TB] FAIL sweep3_r2: got %h want %h", R1, 32'd0);
                end
                nCompared++;
                if (R2 !== 32'h103) begin
                    nMismatched++;
                    $display("[TB] FAIL sweep3_r3: got %h want %h", R2, 32'h103);
                end
            end
            if (!Busy) break;
            busyCnt++;
        end
        Clr = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        nCompared++;
        if (busyCnt !== 32) begin
            nMismatched++;
            $display("[TB] FAIL busy_cycles: got %0d want %0d", busyCnt, 32);
        end
        want = 32'd0;
        for (int i = 0; i < 32; i += 2) begin
            Addr1 = i[4:0];
            Addr2 = 5'(i + 1);
            #1;
            nCompared++;
            if (R1 !== want || R2 !== want) begin
                nMismatched++;
                $display("[TB] FAIL swept_r%0d: got %h/%h want %h", i, R1, R2, want);
            end
        end
        tick();
    endtask

    task automatic test_abort;
        logic [31:0] want;
        fillAll(32'h200);
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
        end
        Addr1 = 5'd10;
        #1;
        nCompared++;
        if (Busy !== 1'b1 || R1 !== 32'h20A) begin
            nMismatched++;
            $display("[TB] FAIL mid_sweep: got busy=%b r10=%h want busy=1 r10=%h", Busy, R1, 32'h20A);
        end
        Rst = 1'b1;
        applyStimulus(1'b1, 5'd20, 32'd77, 1'b0, 5'd0, 32'd0);
        tick();
        Rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        nCompared++;
        if (Busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL abort_busy: got %b want 0", Busy);
        end
        want = 32'd0;
        for (int i = 0; i < 32; i += 2) begin
            Addr1 = i[4:0];
            Addr2 = 5'(i + 1);
            #1;
            nCompared++;
            if (R1 !== want || R2 !== want) begin
                nMismatched++;
                $display("[TB] FAIL abort_r%0d: got %h/%h want %h", i, R1, R2, want);
            end
        end
        tick();
        tick();
        nCompared++;
        if (Busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL no_resume: got %b want 0", Busy);
        end
        applyStimulus(1'b1, 5'd4, 32'd9, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        Addr1 = 5'd4;
        Addr2 = 5'd5;
        #1;
        nCompared++;
        if (R1 !== 32'd9) begin
            nMismatched++;
            $display("[TB] FAIL post_abort_wr: got %h want %h", R1, 32'd9);
        end
        nCompared++;
        if (R2 !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL post_abort_r5: got %h want %h", R2, 32'd0);
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        Rst   = 1'b1;
        Clr   = 1'b0;
        Addr1 = 5'd0;
        Addr2 = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        $display("[TB] start");
        test_reset();
        test_write_read();
        test_same_addr();
        test_zero_reg_dbg();
        test_sweep();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
